// File: rtl/cmd_return_arbiter.sv
// Command-return arbiter: three byte-stream requesters, each with its own
// circular packet buffer, merged onto one output stream in round-robin
// packet order. Packets are stored whole and only emitted once committed,
// so the output never interleaves and never carries a partial packet.
module cmd_return_arbiter #(
  parameter int ADDR_W    = 11,
  parameter int PKT_CNT_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  din0,
  input  logic        din0_en,
  input  logic [7:0]  din1,
  input  logic        din1_en,
  input  logic [7:0]  din2,
  input  logic        din2_en,
  output logic [7:0]  dout,
  output logic        dout_en,
  output logic [15:0] drop_cnt0,
  output logic [15:0] drop_cnt1,
  output logic [15:0] drop_cnt2,
  output logic        busy
);

  localparam int NP     = 3;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int QDEPTH = 1 << PKT_CNT_W;

  typedef logic [ADDR_W-1:0]    ptr_t;
  typedef logic [PKT_CNT_W-1:0] cnt_t;
  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

  localparam cnt_t CNT_MAX = '1;

  // Round-robin successor over ports 0..2.
  function automatic logic [1:0] rr_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  logic [NP-1:0][7:0] din_v;
  logic [NP-1:0]      din_en_v;
  assign din_v    = {din2, din1, din0};
  assign din_en_v = {din2_en, din1_en, din0_en};

  // Arbiter state shared with the per-port blocks.
  state_t     state, state_nx;
  logic [1:0] last;       // last-granted port; also the port being served
  ptr_t       end_ptr;    // end of the packet in flight, captured at grant
  logic       rd_go;      // advance the served port's read pointer this cycle

  // Per-port views exported to the arbiter.
  logic [NP-1:0]              cnt_nz;
  logic [NP-1:0][ADDR_W-1:0]  rd_ptr_w;
  logic [NP-1:0][ADDR_W-1:0]  head_end;
  logic [NP-1:0][7:0]         rd_byte;
  logic [NP-1:0][15:0]        drop_w;

  // Two-flop release synchroniser: writes are only accepted once the
  // deassertion of rst_n has been seen on two clock edges.
  logic [1:0] rst_sync;
  logic       ready;

  // Synchronise reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign ready = rst_sync[1];

  for (genvar i = 0; i < NP; i++) begin : g_port
    logic [7:0] mem   [DEPTH];
    ptr_t       end_q [QDEPTH];   // end pointer of each committed packet
    ptr_t       wr_ptr, cmt_ptr, rd_ptr;
    cnt_t       pkt_cnt, q_head, q_tail;
    logic       bad, in_pkt, armed;
    logic [15:0] drop_cnt;
    logic       wr_en, full, pkt_end, drop, commit, pop, rd_adv, store;

    // Per-port write/commit decode.
    always_comb begin
      // NOTE: every output of a combinational block is assigned on every
      // path (here unconditionally) so no latch is inferred.
      wr_en   = din_en_v[i] & ready & armed;
      full    = (ptr_t'(wr_ptr + 1'b1) == rd_ptr);
      store   = wr_en & ~bad & ~full;
      pkt_end = in_pkt & ~wr_en;
      drop    = pkt_end & (bad | (pkt_cnt == CNT_MAX));
      commit  = pkt_end & ~drop;
      pop     = (state == GAP) && (last == 2'(i));
      rd_adv  = rd_go && (last == 2'(i));
    end

    // Write pointer, commit, drop accounting and packet count.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr   <= '0;
        cmt_ptr  <= '0;
        pkt_cnt  <= '0;
        q_head   <= '0;
        q_tail   <= '0;
        bad      <= 1'b0;
        in_pkt   <= 1'b0;
        armed    <= 1'b0;
        drop_cnt <= '0;
      end else begin
        in_pkt <= wr_en;
        // A requester caught mid-packet by reset is ignored until it idles.
        if (ready && !din_en_v[i]) armed <= 1'b1;
        if (wr_en && !bad) begin
          if (full) bad    <= 1'b1;
          else      wr_ptr <= wr_ptr + 1'b1;
        end
        if (drop) begin
          wr_ptr <= cmt_ptr;
          bad    <= 1'b0;
          if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
        if (commit) begin
          cmt_ptr <= wr_ptr;
          q_tail  <= q_tail + 1'b1;
        end
        if (pop) q_head <= q_head + 1'b1;
        // Commit and GAP retirement on the same cycle cancel out.
        pkt_cnt <= pkt_cnt + cnt_t'(commit) - cnt_t'(pop);
      end
    end

    // Read pointer advances only while this port is being emitted.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      rd_ptr <= '0;
      else if (rd_adv) rd_ptr <= rd_ptr + 1'b1;
    end

    // Packet byte storage and packet-end queue.
    always_ff @(posedge clk) begin
      // NOTE: storage arrays carry no reset; pointers and counts define
      // which entries are valid, so stale contents are never observed.
      if (store)  mem[wr_ptr]   <= din_v[i];
      if (commit) end_q[q_tail] <= wr_ptr;
    end

    assign cnt_nz[i]   = (pkt_cnt != '0);
    assign rd_ptr_w[i] = rd_ptr;
    assign head_end[i] = end_q[q_head];
    assign rd_byte[i]  = mem[rd_ptr];
    assign drop_w[i]   = drop_cnt;
  end

  assign drop_cnt0 = drop_w[0];
  assign drop_cnt1 = drop_w[1];
  assign drop_cnt2 = drop_w[2];

  // Round-robin selection and served-port read mux.
  logic [1:0] c0, c1, c2, pick;
  logic       pick_vld;
  logic [7:0] sel_byte;
  ptr_t       sel_rd;
  logic       at_end;

  // Choose the first port with a committed packet, starting after 'last'.
  always_comb begin
    c0       = rr_next(last);
    c1       = rr_next(c0);
    c2       = rr_next(c1);
    pick     = c0;
    pick_vld = 1'b1;
    if      (cnt_nz[c0]) pick = c0;
    else if (cnt_nz[c1]) pick = c1;
    else if (cnt_nz[c2]) pick = c2;
    else                 pick_vld = 1'b0;
  end

  // Select the served port's read data and detect the packet end.
  always_comb begin
    sel_byte = rd_byte[last];
    sel_rd   = rd_ptr_w[last];
    at_end   = (sel_rd == end_ptr);
    rd_go    = (state == LOAD) || ((state == SEND) && !at_end);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (pick_vld) state_nx = LOAD;
      LOAD: state_nx = SEND;
      SEND: if (at_end) state_nx = GAP;
      GAP:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy    = (state != IDLE);
    dout_en = (state == SEND);
  end

  // Grant capture and output data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last    <= 2'd2;
      end_ptr <= '0;
      dout    <= '0;
    end else begin
      if (state == IDLE && pick_vld) begin
        last    <= pick;
        end_ptr <= head_end[pick];
      end
      if (rd_go)              dout <= sel_byte;
      else if (state == SEND) dout <= '0;
    end
  end

endmodule

// File: doc/cmd_return_arbiter.md
CMD_RETURN_ARBITER -- requirements
Module: cmd_return_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 11, log2 of per-port buffer depth in bytes (2048).
REQ-002 Parameter: PKT_CNT_W, default 6, width of per-port committed-packet counter.
REQ-003 Ports: clk  in  1  single clock for all logic; rst_n  in  1  asynchronous, active-low reset.
REQ-004 Ports: din0 / din0_en  in  8 / 1  requester 0 byte stream; a packet is a maximal run of consecutive en-high cycles.
REQ-005 Ports: din1 / din1_en  in  8 / 1  requester 1 byte stream, same framing.
REQ-006 Ports: din2 / din2_en  in  8 / 1  requester 2 byte stream, same framing.
REQ-007 Ports: dout / dout_en  out  8 / 1  arbitrated command-return stream toward the PCIe command channel.
REQ-008 Ports: drop_cnt0 / drop_cnt1 / drop_cnt2  out  16 each  dropped-packet counters.
REQ-009 Ports: busy  out  1  high while a packet is being emitted.

Function
REQ-010 Each port SHALL own one ADDR_W-deep byte buffer with a write pointer, a committed pointer (packet start) and a read pointer; requesters cannot be back-pressured.
REQ-011 A byte with dinX_en=1 SHALL be written at the write pointer, which then increments modulo 2^ADDR_W.
REQ-012 On the first cycle with dinX_en=0 after a run, the packet SHALL be committed: committed pointer <= write pointer, packet count +1.
REQ-013 Writing SHALL be refused when write pointer + 1 equals read pointer (full); the current packet is then marked bad, and further bytes of that packet are discarded.
REQ-014 At the end of a bad packet, the write pointer SHALL roll back to the committed pointer, the packet count SHALL be unchanged, and drop_cntX SHALL increment, saturating at 16'hFFFF.
REQ-015 Pointer arithmetic SHALL be modulo 2^ADDR_W, and wrap-around SHALL be transparent to packet contents.
REQ-016 The arbiter FSM SHALL have the states IDLE, LOAD, SEND and GAP.
REQ-017 IDLE: if any port has packet count > 0, grant the first such port in round-robin order starting after the last-granted port, then go to LOAD; port 0 is the first candidate after reset.
REQ-018 LOAD: issue the first buffer read for the granted port, then go to SEND.
REQ-019 SEND: emit one byte per cycle with dout_en=1, with no holes, until the read pointer reaches the packet end captured at grant; then go to GAP.
REQ-020 GAP: hold dout_en=0 for exactly one cycle, decrement the granted port's packet count, then return to IDLE.
REQ-021 The packet-count update SHALL handle a simultaneous commit (+1) and GAP decrement (-1) on one port as a net 0 change.
REQ-022 Packet count SHALL saturate: when the count is at maximum, a new packet SHALL be treated as bad (dropped and counted).
REQ-023 Latency: with the FSM in IDLE and all buffers otherwise empty, the first dout byte SHALL appear exactly 3 cycles after the first dinX_en=0 cycle ending the packet.
REQ-024 Output bytes SHALL equal input bytes in order; packets SHALL never interleave; the minimum inter-packet gap on dout SHALL be 1 cycle.
REQ-025 A packet arriving on the granted port during SEND SHALL be buffered normally and SHALL not disturb the packet in flight.
REQ-026 busy SHALL be 1 in LOAD, SEND and GAP, and 0 in IDLE.
REQ-027 Zero-length packets cannot occur by construction, and no action is required for them.

Reset
REQ-028 rst_n=0 SHALL asynchronously clear all pointers, packet counts, bad flags and drop counters.
REQ-029 rst_n=0 SHALL set dout=0, dout_en=0, busy=0, FSM=IDLE, and last-granted port = 2.
REQ-030 Reset asserted mid-packet SHALL abort the packet; no partial packet is emitted after release.
REQ-031 Release of reset SHALL be synchronised internally; the first write is accepted no earlier than the second clk edge after rst_n rises.

Verification
REQ-032 Send the 4-byte packet 8'hA1..A4 on din1 only -> dout shows A1,A2,A3,A4 contiguous, first byte 3 cycles after din1_en falls; busy spans 6 cycles.
REQ-033 Commit 2-byte packets simultaneously on din0, din1 and din2 -> output order is port 0, 1, 2, each packet followed by one dout_en=0 gap cycle.
REQ-034 Send a 2100-byte packet on din2 with ADDR_W=11 -> no output, drop_cnt2=1; a following 10-byte packet is output intact.
REQ-035 Stream 300 packets of 100 bytes on din0 with the write pointer wrapping -> all bytes match in order, drop_cnt0=0.
REQ-036 Assert rst_n=0 during SEND of a 50-byte packet -> dout_en drops immediately, all counters are 0, and nothing is emitted after release until a new packet commits.
